cache_ctrl_fsm: RTL and testbench
=================================

// Module: cache_ctrl_fsm
// PURPOSE
// - Sequencing controller for one 4-way set-associative cache (four_way_set array); sits between the CPU request port and the backing memory.
// - Accepts one byte-wide CPU read/write at a time and performs the tag lookup.
// - On a miss it writes back a dirty victim, refills the line word by word, then replays the access (write-allocate, write-back).
// PARAMETERS
// - ADDRESS_WORD_SIZE  32  CPU/memory byte-address width
// - TAG_SIZE           19  tag bits; index = ADDRESS_WORD_SIZE-TAG_SIZE-OFFSET = 9
// - BLOCK_SIZE         16  line size in bytes; OFFSET = $clog2(BLOCK_SIZE) = 4
// - WORD_SIZE           4  memory word size in bytes; WORDS = BLOCK_SIZE/WORD_SIZE = 4 beats per line
// PORTS
// - clk              in   1     clock; all state changes on posedge
// - rst_b            in   1     reset: synchronous, active-high (1 = reset)
// - cpu_req_valid    in   1     CPU request present
// - cpu_req_ready    out  1     controller accepts request (IDLE only)
// - cpu_rw           in   1     1 = write, 0 = read
// - cpu_addr         in   ADDRESS_WORD_SIZE  byte address
// - cpu_wdata        in   8     write byte
// - cpu_resp_valid   out  1     one-cycle completion pulse (reads and writes)
// - cpu_rdata        out  8     read byte, valid with cpu_resp_valid
// - set_try_read     out  1     lookup/read strobe to the set
// - set_try_write    out  1     write strobe to the set
// - set_address      out  ADDRESS_WORD_SIZE  latched request address
// - set_write_data   out  8     latched write byte
// - set_data         in   8     byte read from the set
// - set_hit_miss     in   1     registered hit flag from the set
// - set_victim_dirty in   1     selected victim way is valid and dirty
// - set_victim_tag   in   TAG_SIZE  victim way tag
// - set_word_idx     out  2     word index for victim read / fill
// - set_word         in   WORD_SIZE*8  victim word at set_word_idx
// - set_fill_en      out  1     write fill word into victim way
// - set_fill_data    out  WORD_SIZE*8  refill word
// - mem_req          out  1     memory request; held until mem_ack
// - mem_we           out  1     1 = writeback beat, 0 = refill beat
// - mem_addr         out  ADDRESS_WORD_SIZE  word-aligned beat address
// - mem_wdata        out  WORD_SIZE*8  writeback data
// - mem_rdata        in   WORD_SIZE*8  refill data, valid with mem_ack
// - mem_ack          in   1     beat complete (one cycle)
// BEHAVIOUR
// - States: IDLE -> LOOKUP -> TAG_CHECK -> {RESPOND | WRITEBACK | REFILL}; WRITEBACK -> REFILL; REFILL -> LOOKUP (replay); RESPOND -> IDLE.
// - Reset: state = IDLE, beat counter = 0. Outputs: cpu_req_ready = 1 (IDLE); all other outputs and strobes = 0; address/data regs = 0.
// - IDLE: cpu_req_ready = 1. On valid & ready, latch cpu_addr/cpu_rw/cpu_wdata and go to LOOKUP.
// - LOOKUP: exactly one cycle of set_try_read (rw = 0) or set_try_write (rw = 1).
// - TAG_CHECK: sample set_hit_miss. Hit -> RESPOND. Miss & set_victim_dirty -> WRITEBACK. Miss & clean -> REFILL.
// - Hit latency: accept edge + 3 cycles; cpu_resp_valid is high during RESPOND for exactly one cycle; cpu_rdata = set_data for reads, 0 for writes.
// - WRITEBACK beat i (0..WORDS-1): mem_req = 1, mem_we = 1, set_word_idx = i, mem_wdata = set_word, mem_addr = {victim_tag, index, i, 2'b00}.
//   - Hold all of these stable until mem_ack; i advances on ack; ack on the last beat -> REFILL with i = 0.
// - REFILL beat i: mem_req = 1, mem_we = 0, mem_addr = {req_tag, index, i, 2'b00}.
//   - On mem_ack: set_fill_en = 1 for one cycle, set_fill_data = mem_rdata, set_word_idx = i.
//   - After the last beat -> LOOKUP; the replay must hit.
// - mem_req drops in the cycle after the last ack of a phase; no idle gap between beats is required.
// - mem_ack while mem_req = 0: ignored.
// - cpu_req_valid outside IDLE: ignored; the request is not latched.
// - Beat counter wraps 3 -> 0 only on phase exit; it is never modified outside WRITEBACK/REFILL.
// - rst_b mid-operation: next edge -> IDLE, mem_req = 0, the in-flight line is abandoned with no fill pulse; the set retains partial data (tag not updated).
// CONFIGURATION
// - CACHE_CTRL_STATS_EN defined:
//   - Adds outputs hit_count[15:0] and miss_count[15:0].
//   - Each increments by 1 in TAG_CHECK of an original (non-replay) access; both saturate at 16'hFFFF; reset to 0.
// - CACHE_CTRL_STATS_EN undefined: neither the ports nor the counters exist; behaviour is otherwise identical.
// STRUCTURE
// - Shared package cache_pkg:
//   - ctrl_state_t enum (IDLE, LOOKUP, TAG_CHECK, RESPOND, WRITEBACK, REFILL);
//   - localparams OFFSET, INDEX_SIZE, WORDS;
//   - function line_addr(tag, index, word).
// - One sub-module: cache_mem_beat_seq (beat counter + mem_req/ack handshake, shared by WRITEBACK and REFILL, with start/done ports).
// TESTING
// - Read miss, clean: read 0x1000_0000 -> 4 refill beats at 0x1000_0000/4/8/C, 4 fill pulses, replay hit, cpu_resp_valid 1 cycle, cpu_rdata = byte 0 of the first refill word.
// - Read hit: re-read 0x1000_0000 -> no mem_req; cpu_resp_valid exactly 3 cycles after the accept edge.
// - Dirty eviction: set_victim_dirty = 1, victim_tag = 0x00002, index 0 -> writeback beats at 0x0000_4000..0x0000_400C with set_word data, then a refill; ordering and addresses checked.
// - Handshake stall: mem_ack delayed 5 cycles per beat -> mem_req/mem_addr/mem_wdata stable throughout; exactly 4 beats per phase.
// - Reset mid-REFILL after beat 1 -> next cycle IDLE, mem_req = 0, cpu_req_ready = 1, no further set_fill_en.
// - With CACHE_CTRL_STATS_EN: 1 miss + 3 hits -> miss_count = 1, hit_count = 3 (replay not counted); preload 16'hFFFE, 3 hits -> 16'hFFFF.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types, geometry constants and address helpers for the
// 4-way set-associative cache controller.
package cache_pkg;

  localparam int ADDRESS_WORD_SIZE = 32;
  localparam int TAG_SIZE          = 19;
  localparam int BLOCK_SIZE        = 16;
  localparam int WORD_SIZE         = 4;
  localparam int OFFSET            = $clog2(BLOCK_SIZE);
  localparam int INDEX_SIZE        =
    ADDRESS_WORD_SIZE - TAG_SIZE - OFFSET;
  localparam int WORDS             = BLOCK_SIZE / WORD_SIZE;
  localparam int WIDX              = $clog2(WORDS);
  localparam int BYTE_OFF          = $clog2(WORD_SIZE);
  localparam int WBITS             = WORD_SIZE * 8;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    TAG_CHECK,
    RESPOND,
    WRITEBACK,
    REFILL
  } ctrl_state_t;

  // Word-aligned byte address of one beat of a line.
  function automatic logic [ADDRESS_WORD_SIZE-1:0] line_addr(
    input logic [TAG_SIZE-1:0]   tag,
    input logic [INDEX_SIZE-1:0] index,
    input logic [WIDX-1:0]       word
  );
    return {tag, index, word, {BYTE_OFF{1'b0}}};
  endfunction

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// Bus bundle between the controller and its CPU, set array and memory.
// master: controller side; slave: CPU / set array / memory side.
interface cache_ctrl_if;
  import cache_pkg::*;

  logic                         cpu_req_valid;
  logic                         cpu_req_ready;
  logic                         cpu_rw;
  logic [ADDRESS_WORD_SIZE-1:0] cpu_addr;
  logic [7:0]                   cpu_wdata;
  logic                         cpu_resp_valid;
  logic [7:0]                   cpu_rdata;

  logic                         set_try_read;
  logic                         set_try_write;
  logic [ADDRESS_WORD_SIZE-1:0] set_address;
  logic [7:0]                   set_write_data;
  logic [7:0]                   set_data;
  logic                         set_hit_miss;
  logic                         set_victim_dirty;
  logic [TAG_SIZE-1:0]          set_victim_tag;
  logic [WIDX-1:0]              set_word_idx;
  logic [WBITS-1:0]             set_word;
  logic                         set_fill_en;
  logic [WBITS-1:0]             set_fill_data;

  logic                         mem_req;
  logic                         mem_we;
  logic [ADDRESS_WORD_SIZE-1:0] mem_addr;
  logic [WBITS-1:0]             mem_wdata;
  logic [WBITS-1:0]             mem_rdata;
  logic                         mem_ack;

  modport master (
    input  cpu_req_valid, cpu_rw, cpu_addr, cpu_wdata,
    input  set_data, set_hit_miss, set_victim_dirty,
    input  set_victim_tag, set_word,
    input  mem_rdata, mem_ack,
    output cpu_req_ready, cpu_resp_valid, cpu_rdata,
    output set_try_read, set_try_write, set_address,
    output set_write_data, set_word_idx, set_fill_en,
    output set_fill_data,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output cpu_req_valid, cpu_rw, cpu_addr, cpu_wdata,
    output set_data, set_hit_miss, set_victim_dirty,
    output set_victim_tag, set_word,
    output mem_rdata, mem_ack,
    input  cpu_req_ready, cpu_resp_valid, cpu_rdata,
    input  set_try_read, set_try_write, set_address,
    input  set_write_data, set_word_idx, set_fill_en,
    input  set_fill_data,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/cache_mem_beat_seq.sv
// Beat counter and mem_req/mem_ack handshake for one line transfer.
// Ports: start_i (begin a phase), mem_ack_i; mem_req_o, beat_o, ack_o, done_o.
module cache_mem_beat_seq
  import cache_pkg::*;
(
  input  logic            clk,
  input  logic            rst_b,
  input  logic            start_i,
  input  logic            mem_ack_i,
  output logic            mem_req_o,
  output logic [WIDX-1:0] beat_o,
  output logic            ack_o,
  output logic            done_o
);

  logic            busy_q, busy_d;
  logic [WIDX-1:0] beat_q, beat_d;

  // Acks are only honoured while a phase is running.
  always_comb begin
    ack_o  = busy_q & mem_ack_i;
    done_o = ack_o & (beat_q == WIDX'(WORDS - 1));
    beat_d = ack_o ? beat_q + WIDX'(1) : beat_q;
    // A restart on done chains writeback into refill with no gap.
    busy_d = start_i | (busy_q & ~done_o);
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      busy_q <= 1'b0;
      beat_q <= '0;
    end else begin
      busy_q <= busy_d;
      beat_q <= beat_d;
    end
  end

  assign mem_req_o = busy_q;
  assign beat_o    = beat_q;

endmodule

// File: rtl/cache_ctrl_fsm.sv
// Cache controller: lookup, dirty writeback, word refill and replay.
// Ports: clk, rst_b, bus (cache_ctrl_if.master); with CACHE_CTRL_STATS_EN
// also hit_count/miss_count (saturating, original accesses only).
module cache_ctrl_fsm
  import cache_pkg::*;
(
  input  logic         clk,
  input  logic         rst_b,
  cache_ctrl_if.master bus
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
`endif
);

  ctrl_state_t                  state_q, state_d;
  logic [ADDRESS_WORD_SIZE-1:0] addr_q, addr_d;
  logic                         rw_q, rw_d;
  logic [7:0]                   wdata_q, wdata_d;

  logic                         seq_start;
  logic                         seq_req;
  logic                         seq_ack;
  logic                         seq_done;
  logic [WIDX-1:0]              seq_beat;

  logic [TAG_SIZE-1:0]          req_tag;
  logic [INDEX_SIZE-1:0]        req_idx;

  assign req_tag = addr_q[ADDRESS_WORD_SIZE-1 -: TAG_SIZE];
  assign req_idx = addr_q[OFFSET +: INDEX_SIZE];

  cache_mem_beat_seq u_beat (
    .clk       (clk),
    .rst_b     (rst_b),
    .start_i   (seq_start),
    .mem_ack_i (bus.mem_ack),
    .mem_req_o (seq_req),
    .beat_o    (seq_beat),
    .ack_o     (seq_ack),
    .done_o    (seq_done)
  );

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    addr_d             = addr_q;
    rw_d               = rw_q;
    wdata_d            = wdata_q;
    seq_start          = 1'b0;
    bus.cpu_req_ready  = 1'b0;
    bus.cpu_resp_valid = 1'b0;
    bus.cpu_rdata      = '0;
    bus.set_try_read   = 1'b0;
    bus.set_try_write  = 1'b0;
    bus.set_word_idx   = '0;
    bus.set_fill_en    = 1'b0;
    bus.set_fill_data  = '0;
    bus.mem_we         = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_wdata      = '0;
    unique case (state_q)
      IDLE: begin
        bus.cpu_req_ready = 1'b1;
        if (bus.cpu_req_valid) begin
          addr_d  = bus.cpu_addr;
          rw_d    = bus.cpu_rw;
          wdata_d = bus.cpu_wdata;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        bus.set_try_read  = ~rw_q;
        bus.set_try_write = rw_q;
        state_d           = TAG_CHECK;
      end
      TAG_CHECK: begin
        if (bus.set_hit_miss) begin
          state_d = RESPOND;
        end else begin
          seq_start = 1'b1;
          state_d   = bus.set_victim_dirty ? WRITEBACK
                                           : REFILL;
        end
      end
      RESPOND: begin
        bus.cpu_resp_valid = 1'b1;
        bus.cpu_rdata      = rw_q ? '0 : bus.set_data;
        state_d            = IDLE;
      end
      WRITEBACK: begin
        bus.mem_we       = 1'b1;
        bus.set_word_idx = seq_beat;
        bus.mem_wdata    = bus.set_word;
        bus.mem_addr     = line_addr(bus.set_victim_tag,
                                     req_idx, seq_beat);
        if (seq_done) begin
          seq_start = 1'b1;
          state_d   = REFILL;
        end
      end
      REFILL: begin
        bus.set_word_idx  = seq_beat;
        bus.mem_addr      = line_addr(req_tag, req_idx,
                                      seq_beat);
        bus.set_fill_en   = seq_ack;
        bus.set_fill_data = seq_ack ? bus.mem_rdata : '0;
        if (seq_done) state_d = LOOKUP;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_req        = seq_req;
  assign bus.set_address    = addr_q;
  assign bus.set_write_data = wdata_q;

`ifdef CACHE_CTRL_STATS_EN
  // replay_q marks the lookup that follows a refill so it is not counted.
  logic        replay_q, replay_d;
  logic [15:0] hit_q, hit_d;
  logic [15:0] miss_q, miss_d;

  always_comb begin
    replay_d = replay_q;
    hit_d    = hit_q;
    miss_d   = miss_q;
    if (state_q == TAG_CHECK) begin
      replay_d = 1'b0;
      if (!replay_q) begin
        if (bus.set_hit_miss) hit_d  = sat_inc16(hit_q);
        else                  miss_d = sat_inc16(miss_q);
      end
    end
    if (state_q == REFILL && seq_done) replay_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      replay_q <= 1'b0;
      hit_q    <= '0;
      miss_q   <= '0;
    end else begin
      replay_q <= replay_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Randomised bench for cache_ctrl_fsm: models set array and memory,
// predicts beats, fills and responses per access.
module tb_cache_ctrl_fsm;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  cache_ctrl_if bus();

`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  cache_ctrl_fsm dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
`ifdef CACHE_CTRL_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  int errs = 0;
  int checks = 0;

  logic [31:0] cur_addr;
  logic        cur_rw;
  logic [7:0]  cur_wdata;
  logic        p_hit;
  logic [7:0]  p_data;
  logic [7:0]  p_wseed;
  int          p_delay;
  int          lk_cnt;
  int          rsp_cnt;
  logic [7:0]  rsp_data;
  logic        spur;
  beat_t       obs_b[$];
  logic [33:0] obs_f[$];

  // Victim word as the set array returns it.
  assign bus.set_word = {p_wseed, 22'h0, bus.set_word_idx};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ ~a[15:0]};
  endfunction

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    logic [31:0] w;
    w = mem_f({a[31:2], 2'b00});
    return w[8*a[1:0] +: 8];
  endfunction

  // Set array + memory responder + monitor; samples mid-cycle,
  // drives just after the rising edge.
  initial begin : env
    int          wait_c;
    logic        prev_req, prev_ack, n_ack, n_hm;
    logic [7:0]  n_data;
    logic [31:0] n_rdata;
    beat_t       cur, prev_b;
    wait_c = 0;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    prev_b = '0;
    forever begin
      @(negedge clk);
      n_ack   = 1'b0;
      n_rdata = bus.mem_rdata;
      n_hm    = bus.set_hit_miss;
      n_data  = bus.set_data;
      if (rst_b) begin
        wait_c   = p_delay;
        prev_req = 1'b0;
        prev_ack = 1'b0;
      end else begin
        if (bus.set_try_read | bus.set_try_write) begin
          chk("lk_addr", bus.set_address, cur_addr);
          chk("lk_kind",
              {30'b0, bus.set_try_write, bus.set_try_read},
              cur_rw ? 32'd2 : 32'd1);
          if (cur_rw)
            chk("lk_wdata", bus.set_write_data, cur_wdata);
          n_hm   = (lk_cnt == 0) ? p_hit : 1'b1;
          n_data = (lk_cnt == 0) ? p_data : rd_byte(cur_addr);
          if (lk_cnt == 0) wait_c = p_delay;
          lk_cnt++;
        end
        if (bus.set_fill_en)
          obs_f.push_back({bus.set_word_idx, bus.set_fill_data});
        if (bus.cpu_resp_valid) begin
          rsp_cnt++;
          rsp_data = bus.cpu_rdata;
        end
        if (bus.mem_req) begin
          cur = '{bus.mem_we, bus.mem_addr, bus.mem_wdata};
          if (prev_req && !prev_ack)
            chk("mem_hold", {31'b0, cur == prev_b}, 32'd1);
          if (bus.mem_ack) begin
            obs_b.push_back(cur);
            wait_c = p_delay;
          end else if (wait_c == 0) begin
            n_ack   = 1'b1;
            n_rdata = mem_f(bus.mem_addr);
          end else begin
            wait_c--;
          end
          prev_b = cur;
        end
        prev_req = bus.mem_req;
        prev_ack = bus.mem_ack;
        if (spur && !bus.mem_req) begin
          n_ack = 1'b1;
          spur  = 1'b0;
        end
      end
      @(posedge clk);
      #1;
      bus.mem_ack      = n_ack;
      bus.mem_rdata    = n_rdata;
      bus.set_hit_miss = n_hm;
      bus.set_data     = n_data;
    end
  end

  task automatic do_req(input logic rw, input logic [31:0] addr,
                        input logic [7:0] wd, input logic hit,
                        input logic dirty, input logic [18:0] vtag,
                        input int delay);
    int          n;
    logic        got;
    logic [7:0]  exp_rd;
    logic [31:0] base_r, base_v, a;
    beat_t       eb[$];
    logic [33:0] ef[$];
    cur_addr = addr;
    cur_rw = rw;
    cur_wdata = wd;
    p_hit = hit;
    p_delay = delay;
    p_data = 8'($urandom);
    p_wseed = 8'($urandom);
    lk_cnt = 0;
    rsp_cnt = 0;
    obs_b.delete();
    obs_f.delete();
    @(posedge clk);
    #1;
    bus.set_victim_dirty = dirty;
    bus.set_victim_tag = vtag;
    bus.cpu_req_valid = 1'b1;
    bus.cpu_rw = rw;
    bus.cpu_addr = addr;
    bus.cpu_wdata = wd;
    @(negedge clk);
    chk("ready", bus.cpu_req_ready, 1);
    @(posedge clk);
    #1;
    // Junk request held while busy must be ignored.
    bus.cpu_addr = $urandom;
    bus.cpu_rw = 1'($urandom);
    bus.cpu_wdata = 8'($urandom);
    n = 0;
    got = 1'b0;
    while (!got && n < 400) begin
      @(negedge clk);
      n++;
      if (bus.cpu_resp_valid) begin
        got = 1'b1;
        chk("rdy_busy", bus.cpu_req_ready, 0);
      end
    end
    chk("resp_seen", got, 1);
    if (hit) chk("hit_lat", n, 3);
    @(posedge clk);
    #1;
    bus.cpu_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    exp_rd = rw ? 8'h00 : (hit ? p_data : rd_byte(addr));
    base_r = {addr[31:4], 4'h0};
    base_v = {vtag, addr[12:4], 4'h0};
    if (!hit) begin
      if (dirty)
        for (int i = 0; i < 4; i++)
          eb.push_back('{1'b1, base_v + 32'(4*i),
                         {p_wseed, 22'h0, 2'(i)}});
      for (int i = 0; i < 4; i++) begin
        a = base_r + 32'(4*i);
        eb.push_back('{1'b0, a, 32'h0});
        ef.push_back({2'(i), mem_f(a)});
      end
    end
    chk("resp_cnt", rsp_cnt, 1);
    chk("rdata", rsp_data, exp_rd);
    chk("lookups", lk_cnt, hit ? 1 : 2);
    chk("beats", obs_b.size(), eb.size());
    for (int i = 0; i < eb.size() && i < obs_b.size(); i++) begin
      chk("b_we", obs_b[i].we, eb[i].we);
      chk("b_addr", obs_b[i].addr, eb[i].addr);
      if (eb[i].we) chk("b_wdata", obs_b[i].data, eb[i].data);
    end
    chk("fills", obs_f.size(), ef.size());
    for (int i = 0; i < ef.size() && i < obs_f.size(); i++) begin
      chk("f_idx", 32'(obs_f[i][33:32]), 32'(ef[i][33:32]));
      chk("f_data", obs_f[i][31:0], ef[i][31:0]);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b0;
  endtask

  initial begin : main
    int   n;
    logic seen;
    bus.cpu_req_valid = 1'b0;
    bus.cpu_rw = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    bus.set_data = '0;
    bus.set_hit_miss = 1'b0;
    bus.set_victim_dirty = 1'b0;
    bus.set_victim_tag = '0;
    bus.mem_rdata = '0;
    bus.mem_ack = 1'b0;
    spur = 1'b0;
    p_delay = 0;
    p_wseed = 8'h00;
    cur_addr = '0;
    cur_rw = 1'b0;
    cur_wdata = '0;
    lk_cnt = 0;
    rsp_cnt = 0;
    rsp_data = '0;
    p_hit = 1'b0;
    p_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_b = 1'b0;
    @(negedge clk);
    chk("rst_ready", bus.cpu_req_ready, 1);
    chk("rst_memreq", bus.mem_req, 0);
    chk("rst_resp", bus.cpu_resp_valid, 0);
    chk("rst_strobe", {bus.set_try_read, bus.set_try_write}, 0);
    chk("rst_setaddr", bus.set_address, 0);
    chk("rst_fill", bus.set_fill_en, 0);
    chk("rst_widx", bus.set_word_idx, 0);

    spur = 1'b1;
    repeat (3) @(negedge clk);

    do_req(1'b0, 32'h1000_0000, 8'h00, 1'b0, 1'b0, 19'h0, 0);
    do_req(1'b0, 32'h1000_0000, 8'h00, 1'b1, 1'b0, 19'h0, 0);
    do_req(1'b0, 32'h2000_0000, 8'h00, 1'b0, 1'b1, 19'h2, 1);
    do_req(1'b1, 32'h1234_5670, 8'hAB, 1'b0, 1'b1,
           19'h1ABCD, 5);

    // Reset in the middle of a refill, after two beats.
    cur_addr = 32'h3000_0040;
    cur_rw = 1'b0;
    p_hit = 1'b0;
    p_delay = 3;
    lk_cnt = 0;
    obs_f.delete();
    obs_b.delete();
    @(posedge clk);
    #1;
    bus.set_victim_dirty = 1'b0;
    bus.cpu_req_valid = 1'b1;
    bus.cpu_rw = 1'b0;
    bus.cpu_addr = cur_addr;
    @(posedge clk);
    #1;
    bus.cpu_req_valid = 1'b0;
    n = 0;
    while (obs_f.size() < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rst_fills_pre", obs_f.size(), 2);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    @(negedge clk);
    chk("mrst_ready", bus.cpu_req_ready, 1);
    chk("mrst_memreq", bus.mem_req, 0);
    chk("mrst_setaddr", bus.set_address, 0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.mem_req | bus.set_fill_en) seen = 1'b1;
    end
    chk("mrst_quiet", seen, 0);
    chk("mrst_fills", obs_f.size(), 2);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(2) == 0) begin
        spur = 1'b1;
        repeat (3) @(negedge clk);
      end
      do_req(1'($urandom), $urandom, 8'($urandom),
             1'($urandom), 1'($urandom), 19'($urandom),
             int'($urandom_range(3)));
    end

`ifdef CACHE_CTRL_STATS_EN
    pulse_reset();
    do_req(1'b0, 32'h4000_0000, 8'h00, 1'b0, 1'b0, 19'h0, 0);
    repeat (3)
      do_req(1'b0, 32'h4000_0000, 8'h00, 1'b1, 1'b0, 19'h0, 0);
    chk("miss_count", miss_count, 16'd1);
    chk("hit_count", hit_count, 16'd3);
    @(posedge clk);
    #1;
    dut.hit_q = 16'hFFFE;
    repeat (3)
      do_req(1'b1, 32'h4000_0004, 8'h11, 1'b1, 1'b0, 19'h0, 0);
    chk("hit_sat", hit_count, 16'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
